nios2_qsys_ram_pipelined: RTL and testbench

- Parametrised successor to the single-port on-chip RAM Avalon-MM slave for the Nios II Qsys system.
- Inferred byte-enabled memory array with a configurable read latency of 1 to 3 cycles.
- Explicit readdatavalid, pipelined reads, a freeze write-lock and an out-of-range guard.
- Serves as instruction/data RAM and scratchpad behind the Qsys interconnect.

---
 rtl/nios2_qsys_ram_pkg.sv | 29 ++
 rtl/nios2_qsys_ram_rdpipe.sv | 62 ++++++
 rtl/nios2_qsys_ram_pipelined.sv | 158 +++++++++++++++
 tb/tb_nios2_qsys_ram_pipelined.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/nios2_qsys_ram_pkg.sv
// -----------------------------------------------------------------------------
// nios2_qsys_ram_pkg
// Shared constants and helper functions for the pipelined Nios II on-chip RAM.
//   BYTE_W           : width of one byte lane
//   READ_LATENCY_MAX : deepest supported read latency
//   clog2()          : ceil(log2(value)), never less than 1
//   byte_parity()    : even-parity bit for one byte lane
// -----------------------------------------------------------------------------
package nios2_qsys_ram_pkg;

    localparam int BYTE_W           = 8;
    localparam int READ_LATENCY_MAX = 3;

    // A one-word memory still needs a one-bit address port.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return (result < 1) ? 1 : result;
    endfunction

    // Stored bit makes the total number of ones in byte+parity even.
    function automatic logic byte_parity(input logic [BYTE_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/nios2_qsys_ram_rdpipe.sv
// -----------------------------------------------------------------------------
// nios2_qsys_ram_rdpipe
// Read-return delay line: STAGES registers of {valid, payload}. All stages
// advance together when en_i is high and hold otherwise. Valid bits clear
// asynchronously on reset_i. STAGES = 0 is a plain wire.
// Ports:
//   clk_i, reset_i   : clock, asynchronous active-high clear
//   en_i             : advance enable
//   in_valid_i/data  : entry from the array output register
//   out_valid_o/data : entry leaving the last stage
// -----------------------------------------------------------------------------
module nios2_qsys_ram_rdpipe #(
    parameter int STAGES = 0,
    parameter int WIDTH  = 33
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en_i,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_data_o
);

    generate
        if (STAGES == 0) begin : g_bypass
            logic unused_ctrl;
            assign unused_ctrl = ^{clk_i, reset_i, en_i};
            assign out_valid_o = in_valid_i;
            assign out_data_o  = in_data_i;
        end else begin : g_pipe
            logic [STAGES-1:0] valid_q;
            logic [WIDTH-1:0]  data_q [STAGES];

            // Payload only loads alongside a valid entry, so the last stage
            // keeps the most recently returned word between reads.
            always_ff @(posedge clk_i or posedge reset_i) begin
                if (reset_i) begin
                    valid_q <= '0;
                    for (int s = 0; s < STAGES; s++) begin
                        data_q[s] <= '0;
                    end
                end else if (en_i) begin
                    valid_q[0] <= in_valid_i;
                    if (in_valid_i) begin
                        data_q[0] <= in_data_i;
                    end
                    for (int s = 1; s < STAGES; s++) begin
                        valid_q[s] <= valid_q[s-1];
                        if (valid_q[s-1]) begin
                            data_q[s] <= data_q[s-1];
                        end
                    end
                end
            end

            assign out_valid_o = valid_q[STAGES-1];
            assign out_data_o  = data_q[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/nios2_qsys_ram_pipelined.sv
// -----------------------------------------------------------------------------
// nios2_qsys_ram_pipelined
// Single-port byte-enabled on-chip RAM, Avalon-MM slave without waitrequest.
// Reads return after READ_LATENCY (1..3) enabled cycles with readdatavalid.
// Optional build macro: NIOS2_QSYS_RAM_PARITY_EN adds a per-byte even-parity
// bit and a per-byte written flag; parity_err reports a mismatch on return.
// Without it parity_err is tied low.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   address, byteenable   : word address, per-byte write lanes
//   chipselect/read/write : Avalon command (write wins over read)
//   writedata             : write data
//   clken, reset_req      : stall controls; either stalls the block
//   freeze                : blocks writes, reads continue
//   readdata/readdatavalid: read return; readdata holds between pulses
//   parity_err            : parity mismatch, only with readdatavalid
// -----------------------------------------------------------------------------
module nios2_qsys_ram_pipelined
    import nios2_qsys_ram_pkg::*;
#(
    parameter int    DATA_W       = 32,
    parameter int    DEPTH        = 2560,
    parameter int    READ_LATENCY = 1,
    parameter string INIT_FILE    = "nios2_qsys_ram.hex",
    localparam int   ADDR_W       = clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDR_W-1:0]        address,
    input  logic [DATA_W/BYTE_W-1:0] byteenable,
    input  logic                     chipselect,
    input  logic                     read,
    input  logic                     write,
    input  logic [DATA_W-1:0]        writedata,
    input  logic                     clken,
    input  logic                     reset_req,
    input  logic                     freeze,
    output logic [DATA_W-1:0]        readdata,
    output logic                     readdatavalid,
    output logic                     parity_err
);

    localparam int NB = DATA_W / BYTE_W;
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

    // Contents are preloaded by the device memory-initialisation flow;
    // the RTL itself never reads the file.
    localparam bit unused_init_file = (INIT_FILE != "");

    logic en;
    logic in_range;
    logic wr_acc;
    logic rd_acc;

    assign en       = clken & ~reset_req;
    assign in_range = {1'b0, address} < DEPTH_LIM;
    assign wr_acc   = chipselect & write & en & ~freeze & in_range;
    assign rd_acc   = chipselect & read & ~write & en;

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            for (int i = 0; i < NB; i++) begin
                if (byteenable[i]) begin
                    mem_q[address][i*BYTE_W +: BYTE_W] <= writedata[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    logic [DATA_W-1:0] rd_word;
    logic              rd_err;

    assign rd_word = in_range ? mem_q[address] : '0;

`ifdef NIOS2_QSYS_RAM_PARITY_EN
    logic [NB-1:0] par_q     [DEPTH];
    logic [NB-1:0] written_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            for (int i = 0; i < NB; i++) begin
                if (byteenable[i]) begin
                    par_q[address][i]     <= byte_parity(writedata[i*BYTE_W +: BYTE_W]);
                    written_q[address][i] <= 1'b1;
                end
            end
        end
    end

    // Bytes never written hold no meaningful parity and are ignored.
    always_comb begin
        rd_err = 1'b0;
        if (in_range) begin
            for (int i = 0; i < NB; i++) begin
                if (written_q[address][i] &&
                    (byte_parity(rd_word[i*BYTE_W +: BYTE_W]) != par_q[address][i])) begin
                    rd_err = 1'b1;
                end
            end
        end
    end
`else
    assign rd_err = 1'b0;
`endif

    // Array output register: first (and for READ_LATENCY=1, only) stage.
    logic            s1_valid_q;
    logic [DATA_W:0] s1_data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
        end else if (en) begin
            s1_valid_q <= rd_acc;
            if (rd_acc) begin
                s1_data_q <= {rd_err, rd_word};
            end
        end
    end

    logic            pipe_valid;
    logic [DATA_W:0] pipe_data;

    nios2_qsys_ram_rdpipe #(
        .STAGES (READ_LATENCY - 1),
        .WIDTH  (DATA_W + 1)
    ) u_rdpipe (
        .clk_i       (clk),
        .reset_i     (reset),
        .en_i        (en),
        .in_valid_i  (s1_valid_q),
        .in_data_i   (s1_data_q),
        .out_valid_o (pipe_valid),
        .out_data_o  (pipe_data)
    );

    // A ready entry is only delivered in an enabled cycle; while stalled it
    // waits in place and readdata keeps showing the previous return.
    logic [DATA_W-1:0] rdata_d;
    logic [DATA_W-1:0] hold_q;

    assign readdatavalid = pipe_valid & en;
    assign rdata_d       = readdatavalid ? pipe_data[DATA_W-1:0] : hold_q;
    assign readdata      = rdata_d;
    assign parity_err    = readdatavalid & pipe_data[DATA_W];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q <= '0;
        end else begin
            hold_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_nios2_qsys_ram_pipelined.sv
module tb_nios2_qsys_ram_pipelined;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] address;
    logic [3:0]  byteenable;
    logic        chipselect, read, write, clken, reset_req, freeze;
    logic [31:0] writedata;

    logic [2:0][31:0] rdata;
    logic [2:0]       rdv;
    logic [2:0]       perr;

    always #5 clk = ~clk;

    nios2_qsys_ram_pipelined #(.READ_LATENCY(1), .INIT_FILE("")) u_l1 (
        .clk(clk), .reset(reset), .address(address), .byteenable(byteenable),
        .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
        .clken(clken), .reset_req(reset_req), .freeze(freeze),
        .readdata(rdata[0]), .readdatavalid(rdv[0]), .parity_err(perr[0]));

    nios2_qsys_ram_pipelined #(.READ_LATENCY(2), .INIT_FILE("")) u_l2 (
        .clk(clk), .reset(reset), .address(address), .byteenable(byteenable),
        .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
        .clken(clken), .reset_req(reset_req), .freeze(freeze),
        .readdata(rdata[1]), .readdatavalid(rdv[1]), .parity_err(perr[1]));

    nios2_qsys_ram_pipelined #(.READ_LATENCY(3), .INIT_FILE("")) u_l3 (
        .clk(clk), .reset(reset), .address(address), .byteenable(byteenable),
        .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
        .clken(clken), .reset_req(reset_req), .freeze(freeze),
        .readdata(rdata[2]), .readdatavalid(rdv[2]), .parity_err(perr[2]));

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          due;
    } sb_item_t;

    typedef struct {
        logic        rd;
        logic        wr;
        logic        frz;
        logic [11:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    sb_item_t exp_q [3][$];
    vec_t     vecs [$];
    int       n_total = 0;
    int       n_pass  = 0;
    int       en_edges = 0;
    int       rdv_cnt [3];
    logic [31:0] last_exp [3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(posedge clk) begin
        if (clken && !reset_req) en_edges++;
    end

    // Scoreboard monitor: each DUT must return its queued reads in order,
    // in the exact enabled cycle they are due.
    always @(negedge clk) begin
        sb_item_t it;
        logic en_now;
        en_now = clken & ~reset_req;
        for (int d = 0; d < 3; d++) begin
            if (rdv[d]) begin
                rdv_cnt[d]++;
                if (!en_now) chk($sformatf("L%0d_rdv_in_stall", d+1), 32'd1, 32'd0);
                if (exp_q[d].size() == 0) begin
                    chk($sformatf("L%0d_unexpected_rdv", d+1), 32'd1, 32'd0);
                end else begin
                    it = exp_q[d].pop_front();
                    chk($sformatf("L%0d_data", d+1), rdata[d], it.data);
                    chk($sformatf("L%0d_parity_err", d+1), {31'd0, perr[d]}, {31'd0, it.err});
                    chk($sformatf("L%0d_latency", d+1), en_edges, it.due);
                    last_exp[d] = it.data;
                end
            end else if (en_now && exp_q[d].size() > 0 && exp_q[d][0].due <= en_edges) begin
                it = exp_q[d].pop_front();
                chk($sformatf("L%0d_missing_rdv", d+1), 32'd0, 32'd1);
            end
        end
    end

    task automatic drive(input logic cs, input logic rd, input logic wr, input logic frz,
                         input logic ce, input logic rr, input logic [11:0] a,
                         input logic [3:0] be, input logic [31:0] wd,
                         input logic [31:0] exp, input logic exp_err);
        sb_item_t it;
        chipselect = cs; read = rd; write = wr; freeze = frz;
        clken = ce; reset_req = rr; address = a; byteenable = be; writedata = wd;
        if (cs && rd && !wr && ce && !rr) begin
            for (int d = 0; d < 3; d++) begin
                it.data = exp; it.err = exp_err; it.due = en_edges + d + 1;
                exp_q[d].push_back(it);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(0, 0, 0, 0, 1, 0, 12'd0, 4'h0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic add_vec(input logic rd, input logic wr, input logic frz, input logic [11:0] a,
                           input logic [3:0] be, input logic [31:0] wd, input logic [31:0] exp);
        vec_t v;
        v.rd = rd; v.wr = wr; v.frz = frz; v.addr = a; v.be = be; v.wdata = wd; v.exp = exp;
        vecs.push_back(v);
    endtask

    initial begin
        int cnt0 [3];

        for (int d = 0; d < 3; d++) begin rdv_cnt[d] = 0; last_exp[d] = 32'd0; end
        //        rd wr frz addr      be    wdata          expected read
        add_vec(0, 1, 0, 12'd0,    4'hF, 32'hA0A0A0A0, 32'h0);
        add_vec(0, 1, 0, 12'd1,    4'hF, 32'hB1B1B1B1, 32'h0);
        add_vec(0, 1, 0, 12'd2,    4'hF, 32'hC2C2C2C2, 32'h0);
        add_vec(0, 1, 0, 12'd3,    4'hF, 32'hD3D3D3D3, 32'h0);
        add_vec(0, 1, 0, 12'd5,    4'hF, 32'hDEADBEEF, 32'h0);
        add_vec(1, 0, 0, 12'd5,    4'h0, 32'h0,        32'hDEADBEEF);
        add_vec(0, 1, 0, 12'd7,    4'hF, 32'h11223344, 32'h0);
        add_vec(0, 1, 0, 12'd7,    4'h5, 32'hAABBCCDD, 32'h0);
        add_vec(1, 0, 0, 12'd7,    4'h0, 32'h0,        32'h11BB33DD);
        add_vec(0, 1, 1, 12'd5,    4'hF, 32'h00000000, 32'h0);
        add_vec(1, 0, 0, 12'd5,    4'h0, 32'h0,        32'hDEADBEEF);
        add_vec(1, 0, 0, 12'd2560, 4'h0, 32'h0,        32'h00000000);
        add_vec(0, 1, 0, 12'd8,    4'hF, 32'h01020304, 32'h0);
        add_vec(0, 1, 0, 12'd8,    4'h0, 32'hCAFEF00D, 32'h0);
        add_vec(0, 1, 0, 12'd8,    4'hA, 32'h55667788, 32'h0);
        add_vec(1, 0, 0, 12'd8,    4'h0, 32'h0,        32'h55027704);
        add_vec(1, 1, 0, 12'd9,    4'hF, 32'h12345678, 32'h0);
        add_vec(1, 0, 0, 12'd9,    4'h0, 32'h0,        32'h12345678);
        add_vec(0, 1, 0, 12'd4095, 4'hF, 32'hFFFFFFFF, 32'h0);
        add_vec(1, 0, 0, 12'd4095, 4'h0, 32'h0,        32'h00000000);
        add_vec(1, 0, 0, 12'd0,    4'h0, 32'h0,        32'hA0A0A0A0);
        add_vec(1, 0, 0, 12'd1,    4'h0, 32'h0,        32'hB1B1B1B1);

        reset = 1'b1;
        chipselect = 0; read = 0; write = 0; freeze = 0; clken = 1; reset_req = 0;
        address = '0; byteenable = '0; writedata = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("L%0d_reset_rdv", d+1), {31'd0, rdv[d]}, 32'd0);
            chk($sformatf("L%0d_reset_rdata", d+1), rdata[d], 32'd0);
            chk($sformatf("L%0d_reset_perr", d+1), {31'd0, perr[d]}, 32'd0);
        end
        reset = 1'b0;
        idle(2);

        foreach (vecs[i])
            drive(1, vecs[i].rd, vecs[i].wr, vecs[i].frz, 1, 0, vecs[i].addr,
                  vecs[i].be, vecs[i].wdata, vecs[i].exp, 1'b0);
        idle(6);

        // Burst of four reads with a three-cycle clken stall in the middle,
        // then a single reset_req stall inside a second burst.
        for (int d = 0; d < 3; d++) cnt0[d] = rdv_cnt[d];
        drive(1, 1, 0, 0, 1, 0, 12'd0, 4'h0, 32'd0, 32'hA0A0A0A0, 1'b0);
        drive(1, 1, 0, 0, 1, 0, 12'd1, 4'h0, 32'd0, 32'hB1B1B1B1, 1'b0);
        repeat (3) drive(1, 1, 0, 0, 0, 0, 12'd7, 4'h0, 32'd0, 32'd0, 1'b0);
        drive(1, 1, 0, 0, 1, 0, 12'd2, 4'h0, 32'd0, 32'hC2C2C2C2, 1'b0);
        drive(1, 1, 0, 0, 1, 0, 12'd3, 4'h0, 32'd0, 32'hD3D3D3D3, 1'b0);
        idle(6);
        for (int d = 0; d < 3; d++)
            chk($sformatf("L%0d_stall_pulses", d+1), rdv_cnt[d] - cnt0[d], 32'd4);

        for (int d = 0; d < 3; d++) cnt0[d] = rdv_cnt[d];
        drive(1, 1, 0, 0, 1, 0, 12'd7, 4'h0, 32'd0, 32'h11BB33DD, 1'b0);
        drive(1, 1, 0, 0, 1, 1, 12'd5, 4'h0, 32'd0, 32'd0, 1'b0);
        drive(1, 1, 0, 0, 1, 0, 12'd8, 4'h0, 32'd0, 32'h55027704, 1'b0);
        idle(6);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("L%0d_req_pulses", d+1), rdv_cnt[d] - cnt0[d], 32'd2);
            chk($sformatf("L%0d_hold_rdata", d+1), rdata[d], last_exp[d]);
        end

        // Reset with two reads in flight: they must vanish.
        drive(1, 1, 0, 0, 1, 0, 12'd5, 4'h0, 32'd0, 32'hDEADBEEF, 1'b0);
        drive(1, 1, 0, 0, 1, 0, 12'd7, 4'h0, 32'd0, 32'h11BB33DD, 1'b0);
        chipselect = 0; read = 0;
        #1;
        reset = 1'b1;
        for (int d = 0; d < 3; d++) exp_q[d].delete();
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("L%0d_async_rst_rdv", d+1), {31'd0, rdv[d]}, 32'd0);
            chk($sformatf("L%0d_async_rst_rdata", d+1), rdata[d], 32'd0);
        end
        for (int d = 0; d < 3; d++) cnt0[d] = rdv_cnt[d];
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        idle(6);
        for (int d = 0; d < 3; d++)
            chk($sformatf("L%0d_post_rst_pulses", d+1), rdv_cnt[d] - cnt0[d], 32'd0);
        drive(1, 1, 0, 0, 1, 0, 12'd5, 4'h0, 32'd0, 32'hDEADBEEF, 1'b0);
        idle(5);

`ifdef NIOS2_QSYS_RAM_PARITY_EN
        u_l1.mem_q[5][0] = ~u_l1.mem_q[5][0];
        u_l2.mem_q[5][0] = ~u_l2.mem_q[5][0];
        u_l3.mem_q[5][0] = ~u_l3.mem_q[5][0];
        drive(1, 1, 0, 0, 1, 0, 12'd5, 4'h0, 32'd0, 32'hDEADBEEE, 1'b1);
        drive(1, 1, 0, 0, 1, 0, 12'd7, 4'h0, 32'd0, 32'h11BB33DD, 1'b0);
        idle(5);
`endif

        idle(4);
        for (int d = 0; d < 3; d++)
            chk($sformatf("L%0d_drain", d+1), exp_q[d].size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
